// File: rtl/word_banner_ctrl.sv
// Text banner sequencer: fetches one word-bitmap ROM row per scan line, shifts it out
// one bit per (scaled) pixel, and gates it through a frame-synchronous show/blink FSM.
module word_banner_ctrl #(
    parameter int X0           = 240,
    parameter int Y0           = 224,
    parameter int SCALE_LOG2   = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         pixel_tick,
    input  logic [9:0]   pixel_x,
    input  logic [9:0]   pixel_y,
    input  logic         video_on,
    input  logic         show,
    input  logic         blink,
    output logic [4:0]   rom_addr,
    input  logic [159:0] rom_data,
    output logic         banner_pixel,
    output logic         banner_region
);

    localparam int         S         = 1 << SCALE_LOG2;
    localparam logic [10:0] X_LO     = 11'(X0);
    localparam logic [10:0] X_HI     = 11'(X0 + 160 * S);
    localparam logic [10:0] Y_LO     = 11'(Y0);
    localparam logic [10:0] Y_HI     = 11'(Y0 + 32 * S);
    localparam logic [10:0] X_ADDR   = 11'(X0 - 2);
    localparam logic [10:0] X_LOAD   = 11'(X0 - 1);
    localparam logic [1:0]  SUB_LAST = 2'(S - 1);
    localparam logic [7:0]  COL_END  = 8'd160;
    localparam logic [5:0]  FCNT_LAST = 6'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_ON,
        ST_BLINK_HI,
        ST_BLINK_LO
    } state_t;

    state_t         state_q, state_d;
    logic [5:0]     fcnt_q, fcnt_d;
    logic [4:0]     rom_addr_q, rom_addr_d;
    logic [159:0]   line_buf_q, line_buf_d;
    logic [7:0]     col_q, col_d;
    logic [1:0]     sub_q, sub_d;

    logic [10:0]    px, py, y_off;
    logic [4:0]     row_idx;
    logic           v_in, h_in, frame_strobe, vis, buf_bit;

    assign px           = {1'b0, pixel_x};
    assign py           = {1'b0, pixel_y};
    assign v_in         = (py >= Y_LO) && (py < Y_HI);
    assign h_in         = (px >= X_LO) && (px < X_HI);
    assign y_off        = py - Y_LO;
    assign row_idx      = 5'(y_off >> SCALE_LOG2);
    assign frame_strobe = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

    assign banner_region = v_in && h_in && video_on;
    // Saturated col (>=160) reads blank, which also blanks a line cut short by reset.
    assign buf_bit       = (col_q < COL_END) ? line_buf_q[col_q] : 1'b0;
    assign banner_pixel  = buf_bit && banner_region && vis;
    assign rom_addr      = rom_addr_q;

    always_comb begin
        rom_addr_d = rom_addr_q;
        line_buf_d = line_buf_q;
        col_d      = col_q;
        sub_d      = sub_q;
        if (pixel_tick && v_in) begin
            if (px == X_ADDR) begin
                rom_addr_d = row_idx;
            end
            if (px == X_LOAD) begin
                line_buf_d = rom_data;
                col_d      = 8'd0;
                sub_d      = 2'd0;
            end
            if (h_in) begin
                if (sub_q == SUB_LAST) begin
                    sub_d = 2'd0;
                    if (col_q < COL_END) begin
                        col_d = col_q + 8'd1;
                    end
                end else begin
                    sub_d = sub_q + 2'd1;
                end
            end
        end
    end

    // Visibility only changes on the frame strobe so a frame is never half drawn.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        vis     = (state_q == ST_ON) || (state_q == ST_BLINK_HI);
        if (frame_strobe) begin
            case (state_q)
                ST_OFF: begin
                    fcnt_d = 6'd0;
                    if (show) begin
                        state_d = blink ? ST_BLINK_HI : ST_ON;
                    end
                end
                ST_ON: begin
                    fcnt_d = 6'd0;
                    if (!show) begin
                        state_d = ST_OFF;
                    end else if (blink) begin
                        state_d = ST_BLINK_HI;
                    end
                end
                ST_BLINK_HI, ST_BLINK_LO: begin
                    if (!show) begin
                        state_d = ST_OFF;
                        fcnt_d  = 6'd0;
                    end else if (!blink) begin
                        state_d = ST_ON;
                        fcnt_d  = 6'd0;
                    end else if (fcnt_q == FCNT_LAST) begin
                        state_d = (state_q == ST_BLINK_HI) ? ST_BLINK_LO : ST_BLINK_HI;
                        fcnt_d  = 6'd0;
                    end else begin
                        fcnt_d = fcnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    fcnt_d  = 6'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_OFF;
            fcnt_q     <= 6'd0;
            rom_addr_q <= 5'd0;
            line_buf_q <= '0;
            col_q      <= COL_END;
            sub_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            fcnt_q     <= fcnt_d;
            rom_addr_q <= rom_addr_d;
            line_buf_q <= line_buf_d;
            col_q      <= col_d;
            sub_q      <= sub_d;
        end
    end

endmodule

// File: tb/tb_word_banner_ctrl.sv
// Directed bench for word_banner_ctrl: scale 1 and scale 2 banners plus a fast-blink
// instance, all driven from one shared pixel stream and checked against a geometric model.
module tb_word_banner_ctrl;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         pixel_tick;
    logic [9:0]   pixel_x, pixel_y;
    logic         video_on, show, blink;
    logic [4:0]   rom_addr0, rom_addr1, rom_addr2;
    logic [159:0] rom_data0, rom_data1, rom_data2;
    logic         pix0, pix1, pix2, reg0, reg1, reg2;
    logic         vis0, vis1, vis2;
    int           n_chk = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    // Row r of the test ROM lights columns 1..12+r; everything else is dark.
    function automatic logic [159:0] rom_row(input logic [4:0] a);
        logic [159:0] r;
        r = '0;
        for (int i = 1; i <= 12 + int'(a); i++) r[i] = 1'b1;
        return r;
    endfunction

    assign rom_data0 = rom_row(rom_addr0);
    assign rom_data1 = rom_row(rom_addr1);
    assign rom_data2 = rom_row(rom_addr2);

    word_banner_ctrl dut0 (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .video_on(video_on), .show(show), .blink(blink),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .banner_pixel(pix0), .banner_region(reg0)
    );

    word_banner_ctrl #(.SCALE_LOG2(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .video_on(video_on), .show(show), .blink(blink),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .banner_pixel(pix1), .banner_region(reg1)
    );

    word_banner_ctrl #(.BLINK_FRAMES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .pixel_tick(pixel_tick), .pixel_x(pixel_x),
        .pixel_y(pixel_y), .video_on(video_on), .show(show), .blink(blink),
        .rom_addr(rom_addr2), .rom_data(rom_data2), .banner_pixel(pix2), .banner_region(reg2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d)", tag, got, exp, pixel_x, pixel_y);
        end
    endtask

    function automatic logic exp_reg(input int x, input int y, input int sl2);
        int s;
        s = 1 << sl2;
        return (x >= 240) && (x < 240 + 160 * s) && (y >= 224) && (y < 224 + 32 * s) && video_on;
    endfunction

    function automatic logic exp_pix(input int x, input int y, input int sl2, input logic vis);
        int col, row;
        if (!exp_reg(x, y, sl2) || !vis) return 1'b0;
        col = (x - 240) >> sl2;
        row = (y - 224) >> sl2;
        return (col >= 1) && (col <= 12 + row);
    endfunction

    task automatic check_all(input int x, input int y);
        chk("pix0", 32'(pix0), 32'(exp_pix(x, y, 0, vis0)));
        chk("pix1", 32'(pix1), 32'(exp_pix(x, y, 1, vis1)));
        chk("pix2", 32'(pix2), 32'(exp_pix(x, y, 0, vis2)));
        chk("reg0", 32'(reg0), 32'(exp_reg(x, y, 0)));
        chk("reg1", 32'(reg1), 32'(exp_reg(x, y, 1)));
        chk("reg2", 32'(reg2), 32'(exp_reg(x, y, 0)));
    endtask

    task automatic step(input int x, input int y, input logic tk);
        @(negedge clk);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        pixel_tick = tk;
        #1;
    endtask

    task automatic strobe();
        step(0, 0, 1'b1);
    endtask

    task automatic draw_span(input int y, input int xa, input int xb);
        for (int x = xa; x <= xb; x++) begin
            step(x, y, 1'b1);
            check_all(x, y);
        end
    endtask

    task automatic draw_line(input int y);
        draw_span(y, 236, 570);
    endtask

    initial begin
        reset_n = 1'b0; pixel_tick = 1'b0; pixel_x = '0; pixel_y = '0;
        video_on = 1'b1; show = 1'b0; blink = 1'b0;
        vis0 = 1'b0; vis1 = 1'b0; vis2 = 1'b0;

        // Reset state
        repeat (3) step(250, 224, 1'b0);
        check_all(250, 224);
        chk("rst_addr0", 32'(rom_addr0), 32'd0);
        chk("rst_addr1", 32'(rom_addr1), 32'd0);
        reset_n = 1'b1;

        // Steady show, first rows and the vertical edges
        show = 1'b1;
        strobe();
        vis0 = 1'b1; vis1 = 1'b1; vis2 = 1'b1;
        draw_line(224);
        chk("addr0_y224", 32'(rom_addr0), 32'd0);
        step(240, 224, 1'b0); chk("y224_x240", 32'(pix0), 32'd0);
        step(241, 224, 1'b0); chk("y224_x241", 32'(pix0), 32'd0);
        draw_line(223);
        draw_line(256);
        draw_line(239);
        chk("addr0_row15", 32'(rom_addr0), 32'd15);
        chk("addr1_row7", 32'(rom_addr1), 32'd7);
        draw_line(226);
        chk("addr1_y226", 32'(rom_addr1), 32'd1);
        chk("addr0_y226", 32'(rom_addr0), 32'd2);
        draw_line(287);
        draw_line(288);

        video_on = 1'b0;
        step(300, 230, 1'b0);
        check_all(300, 230);
        video_on = 1'b1;

        // Blink at 2 frames per half period on dut2; the others stay lit
        blink = 1'b1;
        for (int f = 0; f < 7; f++) begin
            strobe();
            vis2 = ((f % 4) < 2);
            draw_line(224);
        end
        blink = 1'b0;
        draw_line(225);
        strobe();
        vis2 = 1'b1;
        draw_line(226);

        // Hide then show again
        show = 1'b0;
        strobe();
        vis0 = 1'b0; vis1 = 1'b0; vis2 = 1'b0;
        draw_line(224);
        show = 1'b1;
        strobe();
        vis0 = 1'b1; vis1 = 1'b1; vis2 = 1'b1;
        draw_line(228);

        // Asynchronous reset in the middle of a lit line
        draw_span(230, 236, 250);
        chk("pre_rst_pix0", 32'(pix0), 32'd1);
        reset_n = 1'b0;
        #1;
        vis0 = 1'b0; vis1 = 1'b0; vis2 = 1'b0;
        check_all(250, 230);
        chk("rst_mid_addr0", 32'(rom_addr0), 32'd0);
        chk("rst_mid_addr1", 32'(rom_addr1), 32'd0);
        draw_span(230, 251, 259);
        step(260, 230, 1'b1);
        reset_n = 1'b1;
        check_all(260, 230);
        draw_span(230, 261, 570);
        strobe();
        vis0 = 1'b1; vis1 = 1'b1; vis2 = 1'b1;
        draw_line(231);
        chk("post_rst_addr0", 32'(rom_addr0), 32'd7);

        // Pixel-enable stall mid-banner
        draw_span(240, 236, 260);
        for (int i = 0; i < 10; i++) begin
            step(261, 240, 1'b0);
            check_all(261, 240);
        end
        draw_span(240, 261, 570);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/word_banner_ctrl.md
Name: word_banner_ctrl

Overview:
- Sequences the 32-row x 160-column word bitmap ROM to draw a text banner on the VGA pixel stream of the ping-pong game.
- Fetches one ROM row per scan line, buffers it, and shifts it out one bit per pixel, with integer scaling.
- Gates the banner through a frame-synchronous show/blink state machine.
- Sits between the VGA sync generator (pixel_x, pixel_y, pixel_tick) and the top-level colour mux.

Parameters:
- X0, 240, left screen column of the banner (must be >= 2).
- Y0, 224, top screen row of the banner.
- SCALE_LOG2, 0, pixel replication factor log2; legal values 0, 1, 2 (scale 1, 2, 4).
- BLINK_FRAMES, 30, frames per blink half-period; legal range 1..63.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- pixel_tick  in  1  one-cycle pixel enable from the sync generator.
- pixel_x  in  10  current column, 0..799.
- pixel_y  in  10  current row, 0..524.
- video_on  in  1  high in the visible area.
- show  in  1  banner requested.
- blink  in  1  blink requested; only meaningful while show=1.
- rom_addr  out  5  row address to the ROM.
- rom_data  in  160  ROM row; bit 0 is the leftmost pixel.
- banner_pixel  out  1  banner foreground at the current pixel.
- banner_region  out  1  current pixel lies inside the banner rectangle.

Behaviour:
Geometry
- Let S = 1 << SCALE_LOG2, W = 160*S, H = 32*S.
- v_in = (Y0 <= pixel_y < Y0+H).
- h_in = (X0 <= pixel_x < X0+W).
- banner_region = v_in & h_in & video_on; combinational.
- Row index = (pixel_y - Y0) >> SCALE_LOG2, truncated to 5 bits.

Row fetch
- On a pixel_tick with pixel_x == X0-2 and v_in, register rom_addr <= row index.
- rom_addr holds its value otherwise.
- On a pixel_tick with pixel_x == X0-1 and v_in:
  - load line_buf <= rom_data;
  - col <= 0;
  - sub <= 0.

Shift
- On each pixel_tick while h_in & v_in:
  - sub increments;
  - when sub == S-1, sub <= 0 and col <= col+1.
- col is 8 bits and saturates at 160; it never wraps.
- banner_pixel = line_buf[col] & banner_region & vis, where vis is the FSM visibility bit.
- banner_pixel reads 0 whenever col >= 160.

Frame strobe and FSM
- frame_strobe = pixel_tick & pixel_x == 0 & pixel_y == 0.
- States: OFF, ON, BLINK_HI, BLINK_LO.
- State changes occur only on frame_strobe, so there is no mid-frame tearing.
- OFF: vis=0. Go to ON if show & !blink; go to BLINK_HI if show & blink.
- ON: vis=1. Go to OFF if !show; go to BLINK_HI if blink.
- BLINK_HI: vis=1; 6-bit frame counter fcnt increments each strobe.
  - When fcnt == BLINK_FRAMES-1, go to BLINK_LO and clear fcnt.
- BLINK_LO: vis=0; counts the same way, then returns to BLINK_HI.
- From either blink state: !show goes to OFF; show & !blink goes to ON; fcnt clears on both exits.

Reset
- Reset is asynchronous and may arrive mid-line.
- Reset values: rom_addr=0, line_buf=0, col=160, sub=0, fcnt=0, state OFF, so banner_pixel=0.
- Rendering resumes correctly on the first full line fetched after reset release.
- A partially drawn line after reset release draws blank.

Simultaneous events
- Fetch and shift never overlap, because X0-2 and X0-1 lie outside h_in.
- pixel_tick low freezes all registers.

Test Plan:
1. Reset, then show=1, blink=0, defaults. After the next frame_strobe the state is ON.
   - At y=224: rom_addr=0, x=240 gives banner_pixel=0, x=241 gives 1, x=399 gives 0.
   - At y=223 and y=256: banner_pixel=0 everywhere.
2. Same setup, y=239 (row 15). rom_addr=15; banner_pixel=1 for x=241..267.
3. SCALE_LOG2=1:
   - y=226 gives rom_addr=1.
   - Each ROM bit lasts 2 ticks, so x=242,243 show bit 1 = 1.
   - banner_region is high for x=240..559 and y=224..287.
4. show=1, blink=1, BLINK_FRAMES=2. vis follows the frame sequence 1,1,0,0,1,1.
   - Drop blink mid-frame: vis stays unchanged until the next frame_strobe, then reads 1 (ON).
5. Assert reset_n=0 at y=230, x=300 while the banner is visible.
   - banner_pixel=0 immediately, asynchronously, and the state is OFF.
   - After release with show=1, drawing resumes on the next frame with correct rows.
6. Hold pixel_tick=0 for 10 cycles mid-banner. Outputs and col are unchanged, and no column is skipped afterwards.
